// File: rtl/counter_without_gating.sv
// counter_without_gating
//   Free-running binary up-counter with no clock gating and no enable. It is
//   the ungated baseline for clock-gating power/area comparisons. It also
//   carries activity instrumentation: a wrap pulse, a saturating count of
//   output bit toggles, and a saturating count of clocked cycles.
//
// Parameters
//   WIDTH     : count_out width (2..16)
//   STEP      : increment per clock, modulo 2^WIDTH (1..2^WIDTH-1)
//   ACT_WIDTH : width of the activity totals (8..32)
//
// Ports
//   clk          : rising-edge clock, the only clock
//   rst_n        : asynchronous reset, ACTIVE-HIGH despite the name
//   count_out    : registered counter value
//   wrap_out     : registered one-cycle pulse while count_out shows a wrapped value
//   toggle_total : saturating sum of count_out bits flipped per clock
//   cycle_total  : saturating number of clock edges taken out of reset
module counter_without_gating #(
  parameter int WIDTH     = 4,
  parameter int STEP      = 1,
  parameter int ACT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic [WIDTH-1:0]     count_out,
  output logic                 wrap_out,
  output logic [ACT_WIDTH-1:0] toggle_total,
  output logic [ACT_WIDTH-1:0] cycle_total
);

  localparam int POPW = $clog2(WIDTH + 1);

  logic [WIDTH:0]       sum;      // one extra bit so the carry-out flags the wrap
  logic [WIDTH-1:0]     nxt;
  logic [WIDTH-1:0]     flips;
  logic [POPW-1:0]      toggles;
  logic [ACT_WIDTH:0]   tog_sum;  // one extra bit so overflow can be seen and clamped
  logic [ACT_WIDTH-1:0] tog_nxt;
  logic [ACT_WIDTH-1:0] cyc_nxt;

  assign sum   = {1'b0, count_out} + (WIDTH+1)'(STEP);
  assign nxt   = sum[WIDTH-1:0];
  assign flips = count_out ^ nxt;

  always_comb begin
    toggles = '0;
    for (int i = 0; i < WIDTH; i++)
      toggles = toggles + POPW'(flips[i]);
  end

  assign tog_sum = {1'b0, toggle_total} + (ACT_WIDTH+1)'(toggles);
  assign tog_nxt = tog_sum[ACT_WIDTH] ? '1 : tog_sum[ACT_WIDTH-1:0];
  assign cyc_nxt = (&cycle_total) ? cycle_total : cycle_total + 1'b1;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      count_out    <= '0;
      wrap_out     <= 1'b0;
      toggle_total <= '0;
      cycle_total  <= '0;
    end else begin
      count_out    <= nxt;
      wrap_out     <= sum[WIDTH];
      toggle_total <= tog_nxt;
      cycle_total  <= cyc_nxt;
    end
  end

endmodule

// File: tb/tb_counter_without_gating.sv
module tb_counter_without_gating;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // d0: defaults, d1: ACT_WIDTH=8, d2: STEP=3
  logic [3:0]  c0, c1, c2;
  logic        w0, w1, w2;
  logic [15:0] t0, y0, t2, y2;
  logic [7:0]  t1, y1;

  counter_without_gating #(.WIDTH(4), .STEP(1), .ACT_WIDTH(16)) d0 (
    .clk(clk), .rst_n(rst_n), .count_out(c0), .wrap_out(w0), .toggle_total(t0), .cycle_total(y0));
  counter_without_gating #(.WIDTH(4), .STEP(1), .ACT_WIDTH(8)) d1 (
    .clk(clk), .rst_n(rst_n), .count_out(c1), .wrap_out(w1), .toggle_total(t1), .cycle_total(y1));
  counter_without_gating #(.WIDTH(4), .STEP(3), .ACT_WIDTH(16)) d2 (
    .clk(clk), .rst_n(rst_n), .count_out(c2), .wrap_out(w2), .toggle_total(t2), .cycle_total(y2));

  int vectors = 0;
  int errs    = 0;

  // number of rising edges taken out of reset since the last reset
  longint n = 0;
  always @(posedge clk or posedge rst_n)
    if (rst_n) n <= 0;
    else       n <= n + 1;

  // Reference: everything derived from the edge count n.
  function automatic longint m_count(longint k, int w, int s);
    return (k * s) % (longint'(1) << w);
  endfunction

  function automatic longint m_wrap(longint k, int w, int s);
    if (k == 0) return 0;
    return (m_count(k - 1, w, s) + s >= (longint'(1) << w)) ? 1 : 0;
  endfunction

  function automatic longint m_tog(longint k, int w, int s, int a);
    longint tot = 0;
    longint lim = (longint'(1) << a) - 1;
    for (longint j = 0; j < k; j++) begin
      tot += $countones(m_count(j, w, s) ^ m_count(j + 1, w, s));
      if (tot > lim) return lim;
    end
    return tot;
  endfunction

  function automatic longint m_cyc(longint k, int a);
    longint lim = (longint'(1) << a) - 1;
    return (k > lim) ? lim : k;
  endfunction

  task automatic check(input string tag, input longint obs, input longint exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    longint k = n;
    check({tag, ".c0"}, longint'(c0), m_count(k, 4, 1));
    check({tag, ".w0"}, longint'(w0), m_wrap(k, 4, 1));
    check({tag, ".t0"}, longint'(t0), m_tog(k, 4, 1, 16));
    check({tag, ".y0"}, longint'(y0), m_cyc(k, 16));
    check({tag, ".c1"}, longint'(c1), m_count(k, 4, 1));
    check({tag, ".t1"}, longint'(t1), m_tog(k, 4, 1, 8));
    check({tag, ".y1"}, longint'(y1), m_cyc(k, 8));
    check({tag, ".c2"}, longint'(c2), m_count(k, 4, 3));
    check({tag, ".w2"}, longint'(w2), m_wrap(k, 4, 3));
    check({tag, ".t2"}, longint'(t2), m_tog(k, 4, 3, 16));
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".c0"}, longint'(c0), 0);
    check({tag, ".w0"}, longint'(w0), 0);
    check({tag, ".t0"}, longint'(t0), 0);
    check({tag, ".y0"}, longint'(y0), 0);
    check({tag, ".c2"}, longint'(c2), 0);
    check({tag, ".y1"}, longint'(y1), 0);
  endtask

  // advance one clock, sample on the falling edge
  task automatic tick(input string tag);
    @(negedge clk);
    check_model(tag);
  endtask

  // reset at a random point inside the cycle, released on a falling edge
  task automatic reset_pulse(input string tag, input int hold);
    @(negedge clk);
    #($urandom_range(1, 3));
    rst_n = 1'b1;
    #1 check_zero(tag);
    repeat (hold) @(negedge clk);
    check_zero({tag, ".held"});
    rst_n = 1'b0;
  endtask

  initial begin
    int wraps;
    int len;

    // 1: reset held, then first active edge
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_zero("rst");
    rst_n = 1'b0;
    @(negedge clk);
    check("first.count", longint'(c0), 1);
    check("first.cycle", longint'(y0), 1);
    check("first.toggle", longint'(t0), 1);
    check("first.wrap", longint'(w0), 0);

    // 2: one full period
    for (int i = 2; i <= 16; i++) tick("period");
    check("p16.count", longint'(c0), 0);
    check("p16.wrap", longint'(w0), 1);
    check("p16.toggle", longint'(t0), 30);
    check("p16.cycle", longint'(y0), 16);

    // 3: 100 clocks, count wrap pulses
    reset_pulse("r3", 1);
    wraps = 0;
    for (int i = 0; i < 100; i++) begin
      tick("run100");
      if (w0) wraps++;
    end
    check("r100.wraps", longint'(wraps), 6);
    check("r100.count", longint'(c0), 4);
    check("r100.cycle", longint'(y0), 100);
    check("r100.toggle", longint'(t0), 187);

    // 4: async reset while count_out=9, before the next edge
    reset_pulse("r4", 2);
    for (int i = 0; i < 9; i++) tick("to9");
    check("pre.count9", longint'(c0), 9);
    @(posedge clk);
    #2 rst_n = 1'b1;
    #1 check_zero("async");
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("post.count", longint'(c0), 1);

    // 5: ACT_WIDTH=8 saturation after 300 clocks
    reset_pulse("r5", 1);
    for (int i = 0; i < 300; i++) tick("run300");
    check("sat.cycle", longint'(y1), 255);
    check("sat.toggle", longint'(t1), 255);
    check("sat.count", longint'(c1), 12);

    // 6: STEP=3 sequence
    reset_pulse("r6", 1);
    begin
      int seq [6] = '{3, 6, 9, 12, 15, 2};
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        check("step3.count", longint'(c2), longint'(seq[i]));
        check("step3.wrap", longint'(w2), (i == 5) ? 1 : 0);
      end
    end

    // random run lengths with random mid-cycle resets
    for (int r = 0; r < 25; r++) begin
      reset_pulse("rnd.rst", $urandom_range(1, 3));
      len = $urandom_range(1, 60);
      for (int i = 0; i < len; i++) tick("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: observed no finish, expected finish before time limit");
    $fatal(1, "timeout");
  end

endmodule
